// File: rtl/lag_pl_link_arbiter_pkg.sv
// lag_pl_link_arbiter_pkg: shared widths, types and clog2 helper for the PL link arbiter
package lag_pl_link_arbiter_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int n = 4;
  localparam int flit_w = 32;
  localparam int credits = 3;
  localparam int id_w = clog2(n) < 1 ? 1 : clog2(n);
  localparam int cnt_w = clog2(credits + 1);
  typedef logic [flit_w-1:0] flit_t;
  typedef logic [id_w-1:0] pl_id_t;
  typedef logic [cnt_w-1:0] cnt_t;
endpackage

// File: rtl/lag_pl_link_arbiter_rr.sv
// lag_rr_arbiter: round-robin one-hot grant over req (clk, rst, req in; grant, grant_id out), pointer moves to winner
module lag_rr_arbiter
  import lag_pl_link_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] req,
  output logic [n-1:0] grant,
  output pl_id_t       grant_id
);
  pl_id_t ptr;
  pl_id_t c;
  always_comb begin
    grant = '0;
    grant_id = ptr;
    c = ptr;
    for (int k = 1; k <= n; k++) begin
      c = pl_id_t'((int'(ptr) + k) % n);
      if (grant == '0 && req[c]) begin
        grant[c] = 1'b1;
        grant_id = c;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) ptr <= pl_id_t'(n - 1);
    else if (|req) ptr <= grant_id;
endmodule

// File: rtl/lag_pl_link_arbiter.sv
// lag_pl_link_arbiter: credit-gated RR pop of PL FIFO heads onto the link (pl_empty/pl_head/credit_in in; pl_pop, out_valid/out_flit/out_pl_id, credit_err out)
module lag_pl_link_arbiter
  import lag_pl_link_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [n-1:0]        pl_empty,
  input  logic [n*flit_w-1:0] pl_head,
  output logic [n-1:0]        pl_pop,
  input  logic [n-1:0]        credit_in,
  output logic                out_valid,
  output flit_t               out_flit,
  output pl_id_t              out_pl_id,
  output logic                credit_err
);
  cnt_t cnt [n];
  logic [n-1:0] eligible, grant, ovf;
  pl_id_t grant_id;
  flit_t sel;
  always_comb begin
    eligible = '0;
    ovf = '0;
    sel = '0;
    for (int i = 0; i < n; i++) begin
      eligible[i] = !rst && !pl_empty[i] && cnt[i] != '0;
      ovf[i] = credit_in[i] && !grant[i] && cnt[i] == cnt_t'(credits);
      sel = sel | (pl_head[i*flit_w +: flit_w] & {flit_w{grant[i]}});
    end
  end
  lag_rr_arbiter u_rr (.clk(clk), .rst(rst), .req(eligible), .grant(grant), .grant_id(grant_id));
  assign pl_pop = grant;
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < n; i++) cnt[i] <= cnt_t'(credits);
      out_valid <= 1'b0;
      out_flit <= '0;
      out_pl_id <= '0;
      credit_err <= 1'b0;
    end else begin
      for (int i = 0; i < n; i++)
        if (!ovf[i]) cnt[i] <= cnt[i] - cnt_t'(grant[i]) + cnt_t'(credit_in[i]);
      out_valid <= |grant;
      if (|grant) begin
        out_flit <= sel;
        out_pl_id <= grant_id;
      end
      credit_err <= credit_err | (|ovf);
    end
endmodule

// File: tb/tb_lag_pl_link_arbiter.sv
// tb_lag_pl_link_arbiter: directed self-checking bench for lag_pl_link_arbiter
module tb_lag_pl_link_arbiter;
  import lag_pl_link_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [n-1:0] pl_empty, pl_pop, credit_in;
  logic [n*flit_w-1:0] pl_head;
  logic out_valid, credit_err;
  flit_t out_flit;
  pl_id_t out_pl_id;
  int total = 0;
  int bad = 0;
  lag_pl_link_arbiter dut (.clk(clk), .rst(rst), .pl_empty(pl_empty), .pl_head(pl_head), .pl_pop(pl_pop),
    .credit_in(credit_in), .out_valid(out_valid), .out_flit(out_flit), .out_pl_id(out_pl_id), .credit_err(credit_err));
  always #5 clk = ~clk;
  function automatic flit_t hv(input int i, input int tag);
    return flit_t'(32'h1000_0000 * (i + 1) + tag);
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_heads(input int tag);
    for (int i = 0; i < n; i++) pl_head[i*flit_w +: flit_w] = hv(i, tag);
  endtask
  task automatic test_reset;
    rst = 1'b1; pl_empty = '1; credit_in = '0; set_heads(0);
    step; step;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (pl_pop !== 4'b0000) begin bad++; $display("FAIL reset_pop got=%b want=0000", pl_pop); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", credit_err); end
    total++; if (out_flit !== 32'h0) begin bad++; $display("FAIL reset_flit got=%h want=0", out_flit); end
    total++; if (out_pl_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", out_pl_id); end
    pl_empty = '0; #1;
    total++; if (pl_pop !== 4'b0000) begin bad++; $display("FAIL reset_pop_masked got=%b want=0000", pl_pop); end
    pl_empty = '1; rst = 1'b0;
  endtask
  task automatic test_fairness;
    pl_empty = '0;
    for (int c = 0; c < 8; c++) begin
      set_heads(c + 1);
      credit_in = 4'(1 << (c % 4));
      #1;
      total++; if (pl_pop !== 4'(1 << (c % 4))) begin bad++; $display("FAIL fair_pop[%0d] got=%b want=%b", c, pl_pop, 4'(1 << (c % 4))); end
      step;
      total++; if (out_valid !== 1'b1 || out_pl_id !== 2'(c % 4)) begin bad++; $display("FAIL fair_id[%0d] got=%b/%0d want=1/%0d", c, out_valid, out_pl_id, c % 4); end
      total++; if (out_flit !== hv(c % 4, c + 1)) begin bad++; $display("FAIL fair_flit[%0d] got=%h want=%h", c, out_flit, hv(c % 4, c + 1)); end
    end
    pl_empty = '1; credit_in = '0;
    step;
    total++; if (out_valid !== 1'b0 || out_flit !== hv(3, 8)) begin bad++; $display("FAIL idle_hold got=%b/%h want=0/%h", out_valid, out_flit, hv(3, 8)); end
  endtask
  task automatic test_exhaustion;
    pl_empty = 4'b1011; credit_in = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (pl_pop !== 4'b0100) begin bad++; $display("FAIL exh_pop[%0d] got=%b want=0100", k, pl_pop); end
      step;
      total++; if (out_valid !== 1'b1 || out_pl_id !== 2'd2) begin bad++; $display("FAIL exh_out[%0d] got=%b/%0d want=1/2", k, out_valid, out_pl_id); end
    end
    #1;
    total++; if (pl_pop !== 4'b0000) begin bad++; $display("FAIL exh_stop got=%b want=0000", pl_pop); end
    step;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL exh_idle got=%b want=0", out_valid); end
    credit_in = 4'b0100; #1;
    total++; if (pl_pop !== 4'b0000) begin bad++; $display("FAIL exh_nobypass got=%b want=0000", pl_pop); end
    step;
    credit_in = '0; #1;
    total++; if (pl_pop !== 4'b0100) begin bad++; $display("FAIL exh_refill got=%b want=0100", pl_pop); end
    step;
    total++; if (out_valid !== 1'b1 || out_pl_id !== 2'd2) begin bad++; $display("FAIL exh_refill_out got=%b/%0d want=1/2", out_valid, out_pl_id); end
    #1;
    total++; if (pl_pop !== 4'b0000) begin bad++; $display("FAIL exh_once got=%b want=0000", pl_pop); end
    pl_empty = '1; credit_in = 4'b0100;
    step; step; step;
    credit_in = '0;
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL exh_err got=%b want=0", credit_err); end
  endtask
  task automatic test_simultaneous;
    pl_empty = 4'b1101; credit_in = '0;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (pl_pop !== 4'b0010) begin bad++; $display("FAIL sim_drain[%0d] got=%b want=0010", k, pl_pop); end
      step;
    end
    credit_in = 4'b0010; #1;
    total++; if (pl_pop !== 4'b0010) begin bad++; $display("FAIL sim_both got=%b want=0010", pl_pop); end
    step;
    credit_in = '0; #1;
    total++; if (pl_pop !== 4'b0010) begin bad++; $display("FAIL sim_again got=%b want=0010", pl_pop); end
    step; #1;
    total++; if (pl_pop !== 4'b0000) begin bad++; $display("FAIL sim_empty got=%b want=0000", pl_pop); end
    pl_empty = '1; credit_in = 4'b0010;
    step; step; step;
    credit_in = '0;
  endtask
  task automatic test_overflow;
    pl_empty = '1; credit_in = 4'b0001;
    step;
    credit_in = '0;
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b want=1", credit_err); end
    step; step;
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", credit_err); end
    pl_empty = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (pl_pop !== 4'b0001) begin bad++; $display("FAIL ovf_pop[%0d] got=%b want=0001", k, pl_pop); end
      step;
    end
    #1;
    total++; if (pl_pop !== 4'b0000) begin bad++; $display("FAIL ovf_sat got=%b want=0000", pl_pop); end
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_held got=%b want=1", credit_err); end
    pl_empty = '1; credit_in = 4'b0001;
    step; step; step;
    credit_in = '0;
  endtask
  task automatic test_midreset;
    pl_empty = 4'b1101; #1;
    total++; if (pl_pop !== 4'b0010) begin bad++; $display("FAIL mr_stream got=%b want=0010", pl_pop); end
    step;
    total++; if (out_valid !== 1'b1 || out_pl_id !== 2'd1) begin bad++; $display("FAIL mr_out got=%b/%0d want=1/1", out_valid, out_pl_id); end
    rst = 1'b1; #1;
    total++; if (pl_pop !== 4'b0000) begin bad++; $display("FAIL mr_nopop got=%b want=0000", pl_pop); end
    step;
    total++; if (out_valid !== 1'b0 || credit_err !== 1'b0) begin bad++; $display("FAIL mr_clear got=%b/%b want=0/0", out_valid, credit_err); end
    total++; if (out_flit !== 32'h0 || out_pl_id !== 2'd0) begin bad++; $display("FAIL mr_outs got=%h/%0d want=0/0", out_flit, out_pl_id); end
    rst = 1'b0; pl_empty = '0; set_heads(99); #1;
    total++; if (pl_pop !== 4'b0001) begin bad++; $display("FAIL mr_first got=%b want=0001", pl_pop); end
    step;
    total++; if (out_pl_id !== 2'd0 || out_flit !== hv(0, 99)) begin bad++; $display("FAIL mr_first_out got=%0d/%h want=0/%h", out_pl_id, out_flit, hv(0, 99)); end
    pl_empty = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (pl_pop !== 4'b0010) begin bad++; $display("FAIL mr_reload[%0d] got=%b want=0010", k, pl_pop); end
      step;
    end
    #1;
    total++; if (pl_pop !== 4'b0000) begin bad++; $display("FAIL mr_reload_end got=%b want=0000", pl_pop); end
    pl_empty = '1;
  endtask
  initial begin
    test_reset;
    test_fairness;
    test_exhaustion;
    test_simultaneous;
    test_overflow;
    test_midreset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
